// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller.
//   state_e    : controller FSM encoding (IDLE/RUN/PAUSE/LAP)
//   AN_UNITS   : active-low anode pattern selecting the units digit
//   AN_TENS    : active-low anode pattern selecting the tens digit
//   is_running : true in the states where the prescaler advances
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_e;

    localparam logic [1:0] AN_UNITS = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;

    function automatic logic is_running(state_e s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button and display bundle of the stopwatch controller.
//   start_stop, clear, lap : raw asynchronous push-button levels
//   ones, tens             : live seconds count (BCD)
//   run                    : high in RUN or LAP
//   min_pulse              : one-cycle pulse on the 59->00 wrap
//   an, digit              : multiplexed display drive (active-low anodes)
//   state                  : current FSM state, for observation
// Signalling: there is no valid/ready handshake on this bundle. Buttons are
// raw levels that the controller synchronises itself; every output is a
// registered level that is meaningful on every clock cycle.
interface stopwatch_ctrl_if;
    import stopwatch_ctrl_pkg::*;

    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] ones;
    logic [2:0] tens;
    logic       run;
    logic       min_pulse;
    logic [1:0] an;
    logic [3:0] digit;
    state_e     state;

    modport master (
        output start_stop, clear, lap,
        input  ones, tens, run, min_pulse, an, digit, state
    );

    modport slave (
        input  start_stop, clear, lap,
        output ones, tens, run, min_pulse, an, digit, state
    );

endinterface

// File: rtl/stopwatch_ctrl_bcd_digit_cnt.sv
// One BCD digit counter that counts 0..MAX and wraps to 0.
//   mclk, reset : clock and asynchronous active-high reset
//   clr         : synchronous clear, wins over en
//   en          : advance by one this cycle
//   cnt         : current digit value
//   tc          : terminal count, en & (cnt == MAX); carry into the next digit
module bcd_digit_cnt #(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         mclk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_max;

    assign at_max = (cnt_q == W'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_max ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = en & at_max;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear controller for a 00-59 second BCD stopwatch with a
// two-digit multiplexed 7-segment display.
//   mclk  : single system clock
//   reset : asynchronous active-high reset
//   sw    : button inputs and display/status outputs (slave side)
// Parameters: DIV (mclk cycles per count tick, >= 2) and SCAN_DIV (mclk
// cycles each digit is driven, >= 1).
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DIV      = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic             mclk,
    input  logic             reset,
    stopwatch_ctrl_if.slave  sw
);

    localparam int PW = $clog2(DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // ---------------- button conditioning ----------------
    // Bit order {lap, clear, start_stop}. The chain resets to all-ones so a
    // button already held at reset looks "previously pressed" and needs a
    // fresh release/press before it produces an event.
    logic [2:0] btn_raw;
    logic [2:0] meta_q, sync_q, prev_q;
    logic [2:0] btn_ev;
    logic       ss_ev, clr_ev, lap_ev;

    assign btn_raw = {sw.lap, sw.clear, sw.start_stop};

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            meta_q <= 3'b111;
            sync_q <= 3'b111;
            prev_q <= 3'b111;
        end else begin
            meta_q <= btn_raw;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign btn_ev = sync_q & ~prev_q;
    assign ss_ev  = btn_ev[0];
    assign clr_ev = btn_ev[1];
    assign lap_ev = btn_ev[2];

    // ---------------- control FSM ----------------
    state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ss_ev) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ss_ev)       state_d = ST_PAUSE;
                else if (lap_ev) state_d = ST_LAP;
            end
            ST_LAP: begin
                if (ss_ev)       state_d = ST_PAUSE;
                else if (lap_ev) state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (clr_ev)     state_d = ST_IDLE;
                else if (ss_ev) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    logic enter_idle;
    logic lap_entry;
    logic running;

    assign enter_idle = (state_d == ST_IDLE) && (state_q != ST_IDLE);
    assign lap_entry  = (state_q == ST_RUN) && (state_d == ST_LAP);
    assign running    = is_running(state_q);

    // ---------------- prescaler ----------------
    // Holds in PAUSE so a resume completes the interrupted second.
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    assign tick = running && (presc_q == PW'(DIV - 1));

    always_comb begin
        presc_d = presc_q;
        if (enter_idle) begin
            presc_d = '0;
        end else if (running) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ---------------- digit counters ----------------
    logic [3:0] ones_cnt;
    logic [2:0] tens_cnt;
    logic       ones_tc, tens_tc;
    logic       min_pulse_q;

    bcd_digit_cnt #(.MAX(9), .W(4)) u_ones (
        .mclk  (mclk),
        .reset (reset),
        .clr   (enter_idle),
        .en    (tick),
        .cnt   (ones_cnt),
        .tc    (ones_tc)
    );

    bcd_digit_cnt #(.MAX(5), .W(3)) u_tens (
        .mclk  (mclk),
        .reset (reset),
        .clr   (enter_idle),
        .en    (ones_tc),
        .cnt   (tens_cnt),
        .tc    (tens_tc)
    );

    // tens_tc is high exactly on the tick that takes 59 back to 00.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            min_pulse_q <= 1'b0;
        end else begin
            min_pulse_q <= tens_tc;
        end
    end

    // ---------------- lap snapshot ----------------
    logic [3:0] snap_ones_q, snap_ones_d;
    logic [2:0] snap_tens_q, snap_tens_d;
    logic [3:0] disp_ones;
    logic [2:0] disp_tens;

    always_comb begin
        snap_ones_d = snap_ones_q;
        snap_tens_d = snap_tens_q;
        if (lap_entry) begin
            snap_ones_d = ones_cnt;
            snap_tens_d = tens_cnt;
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            snap_ones_q <= '0;
            snap_tens_q <= '0;
        end else begin
            snap_ones_q <= snap_ones_d;
            snap_tens_q <= snap_tens_d;
        end
    end

    assign disp_ones = (state_q == ST_LAP) ? snap_ones_q : ones_cnt;
    assign disp_tens = (state_q == ST_LAP) ? snap_tens_q : tens_cnt;

    // ---------------- display scan ----------------
    logic [SW-1:0] scan_q, scan_d;
    logic [1:0]    an_q, an_d;
    logic [3:0]    digit_q, digit_d;
    logic          scan_wrap;

    assign scan_wrap = (scan_q == SW'(SCAN_DIV - 1));

    // digit is selected with the next anode value so that the registered
    // digit and the registered anode always refer to the same position.
    always_comb begin
        scan_d  = scan_wrap ? '0 : scan_q + SW'(1);
        an_d    = scan_wrap ? ~an_q : an_q;
        digit_d = (an_d == AN_UNITS) ? disp_ones : {1'b0, disp_tens};
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            scan_q  <= '0;
            an_q    <= AN_UNITS;
            digit_q <= '0;
        end else begin
            scan_q  <= scan_d;
            an_q    <= an_d;
            digit_q <= digit_d;
        end
    end

    // ---------------- outputs ----------------
    assign sw.ones      = ones_cnt;
    assign sw.tens      = tens_cnt;
    assign sw.run       = running;
    assign sw.min_pulse = min_pulse_q;
    assign sw.an        = an_q;
    assign sw.digit     = digit_q;
    assign sw.state     = state_q;

endmodule
